// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: row/bit-plane scan sequencer for a HUB75 panel.
// Steps through every (row, bit-plane) pair. For each pair it starts the
// shifter, waits for the shift to finish and for the current plane's display
// time to run out, then blanks, latches and lights the new plane. Lit time
// uses binary-coded modulation: BASE_TIME << bit cycles.
// Optional build macro HUB75_BRIGHTNESS_EN adds an 8-bit global brightness
// input that shortens the lit part of each plane. The plane period does not
// change.
module hub75_scan_ctrl #(
    parameter int ROWS         = 32,
    parameter int BITS         = 8,
    parameter int BASE_TIME    = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0] brightness,
`endif
    output logic       fetch_start,
    input  logic       fetch_busy,
    output logic [2:0] bit_cnt,
    output logic [5:0] row_cnt,
    output logic [4:0] addr,
    output logic       lat,
    output logic       oe_n,
    output logic       frame_done
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_SHIFTING   = 3'd2;
    localparam logic [2:0] S_WAIT_DISP  = 3'd3;
    localparam logic [2:0] S_BLANK_PRE  = 3'd4;
    localparam logic [2:0] S_LATCH      = 3'd5;
    localparam logic [2:0] S_BLANK_POST = 3'd6;
    localparam logic [2:0] S_UNBLANK    = 3'd7;

    localparam logic [2:0]  LAST_BIT   = 3'(BITS - 1);
    localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);
    localparam logic [15:0] BASE_T     = 16'(BASE_TIME);
    localparam logic [7:0]  BLANK_LOAD = 8'(BLANK_CYCLES - 1);

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [15:0] timer_r;       // plane period countdown; gates leaving WAIT_DISP
    logic [15:0] lit_r;         // lit-cycle countdown; oe_n rises when it expires
    logic [7:0]  blank_r;
    logic [2:0]  disp_bit_r;    // bit-plane currently latched into the panel
    logic [15:0] plane_time_s;
    logic [15:0] lit_time_s;
    logic        last_bit_s;
    logic        last_row_s;

    assign plane_time_s = BASE_T << disp_bit_r;
    assign last_bit_s   = (bit_cnt == LAST_BIT);
    assign last_row_s   = (row_cnt == LAST_ROW);

`ifdef HUB75_BRIGHTNESS_EN
    logic [23:0] scaled_s;

    // Scale the plane period by (brightness+1)/256, never below one lit cycle
    always_comb begin
        scaled_s = 24'(plane_time_s) * (24'(brightness) + 24'd1);
        if ((scaled_s >> 8) == 24'd0) begin
            lit_time_s = 16'd1;
        end else begin
            lit_time_s = 16'(scaled_s >> 8);
        end
    end
`else
    // Full-brightness build: the plane is lit for its whole period
    always_comb begin
        lit_time_s = plane_time_s;
    end
`endif

    // Next-state decode of the scan sequencer
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (enable) next_state_s = S_START;
                else        next_state_s = S_IDLE;
            end
            S_START: begin
                next_state_s = S_SHIFTING;
            end
            S_SHIFTING: begin
                if (!fetch_busy) next_state_s = S_WAIT_DISP;
                else             next_state_s = S_SHIFTING;
            end
            S_WAIT_DISP: begin
                if (timer_r == 16'd0) next_state_s = S_BLANK_PRE;
                else                  next_state_s = S_WAIT_DISP;
            end
            S_BLANK_PRE: begin
                if (blank_r == 8'd0) next_state_s = S_LATCH;
                else                 next_state_s = S_BLANK_PRE;
            end
            S_LATCH: begin
                next_state_s = S_BLANK_POST;
            end
            S_BLANK_POST: begin
                if (blank_r == 8'd0) next_state_s = S_UNBLANK;
                else                 next_state_s = S_BLANK_POST;
            end
            S_UNBLANK: begin
                // enable only matters at the frame wrap
                if (last_bit_s && last_row_s && !enable) next_state_s = S_IDLE;
                else                                     next_state_s = S_START;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State register and the strobe outputs decoded one cycle ahead
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            fetch_start <= 1'b0;
            lat         <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            fetch_start <= (next_state_s == S_START);
            lat         <= (next_state_s == S_LATCH);
            frame_done  <= (next_state_s == S_LATCH) && last_bit_s && last_row_s;
        end
    end

    // Blank-interval counter, reloaded on entry to either blank state
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            blank_r <= 8'd0;
        end else if ((next_state_s == S_BLANK_PRE  && state_r != S_BLANK_PRE) ||
                     (next_state_s == S_BLANK_POST && state_r != S_BLANK_POST)) begin
            blank_r <= BLANK_LOAD;
        end else if (blank_r != 8'd0) begin
            blank_r <= blank_r - 8'd1;
        end else begin
            blank_r <= blank_r;
        end
    end

    // Capture row address and displayed bit as the latch pulse is issued
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            addr       <= 5'd0;
            disp_bit_r <= 3'd0;
        end else if (next_state_s == S_LATCH) begin
            addr       <= row_cnt[4:0];
            disp_bit_r <= bit_cnt;
        end else begin
            addr       <= addr;
            disp_bit_r <= disp_bit_r;
        end
    end

    // Plane counters; they move only in UNBLANK so the shifter sees them stable
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            row_cnt <= 6'd0;
        end else if (state_r == S_UNBLANK) begin
            if (last_bit_s) begin
                bit_cnt <= 3'd0;
                if (last_row_s) row_cnt <= 6'd0;
                else            row_cnt <= row_cnt + 6'd1;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
                row_cnt <= row_cnt;
            end
        end else begin
            bit_cnt <= bit_cnt;
            row_cnt <= row_cnt;
        end
    end

    // Display timers and output enable: lit from UNBLANK until the lit count expires
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            timer_r <= 16'd0;
            lit_r   <= 16'd0;
            oe_n    <= 1'b1;
        end else if (state_r == S_UNBLANK) begin
            timer_r <= plane_time_s;
            lit_r   <= lit_time_s;
            oe_n    <= 1'b0;
        end else begin
            if (timer_r != 16'd0) timer_r <= timer_r - 16'd1;
            else                  timer_r <= timer_r;
            if (lit_r != 16'd0)   lit_r <= lit_r - 16'd1;
            else                  lit_r <= lit_r;
            if (lit_r == 16'd1)   oe_n <= 1'b1;
            else                  oe_n <= oe_n;
        end
    end

endmodule
